// File: rtl/cpu16_loader_pkg.sv
// Shared types and constants for the switch-driven instruction-memory loader.
// State encoding, nibble width and nibbles-per-word.
package cpu16_loader_pkg;

  localparam int NIB_W = 4;
  localparam int NIB   = 4;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    FULL
  } state_e;

endpackage

// File: rtl/btn_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and
// a one-cycle pulse on each accepted rising level.
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1_q;
  logic          s2_q;
  logic          level_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;
  logic          hit;

  // Level flips on the Nth consecutive synced sample that disagrees.
  assign hit = (s2_q != level_q) &&
               (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q   <= btn_i;
      s2_q   <= s1_q;
      rise_q <= hit & s2_q;
      if (s2_q == level_q) begin
        cnt_q <= '0;
      end else if (hit) begin
        cnt_q   <= '0;
        level_q <= s2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/imem_switch_loader.sv
// Assembles switch nibbles into instruction words and writes them to IMEM.
// Optional running XOR checksum: define LOADER_CHECKSUM_EN.
module imem_switch_loader
  import cpu16_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 16
) (
  input  logic              Clk_100MHz,
  input  logic              Reset,
  input  logic [3:0]        Nibble_Sw,
  input  logic              Enter_Btn,
  input  logic              Load_Mode,
  output logic              IMem_WrEn,
  output logic [ADDR_W-1:0] IMem_WrAddr,
  output logic [DATA_W-1:0] IMem_WrData,
  output logic              Cpu_Hold,
  output logic              Cpu_Restart,
  output logic [1:0]        Nib_Idx,
  output logic              Load_Full,
  output logic [DATA_W-1:0] Checksum
);

  localparam int NIBS  = DATA_W / NIB_W;
  localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              restart_q, restart_d;
  logic              lm_s1_q, lm_s2_q;
  logic              enter;
  logic              start;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter (
    .clk_i (Clk_100MHz),
    .rst_i (Reset),
    .btn_i (Enter_Btn),
    .rise_o(enter)
  );

  assign start = (state_q == IDLE) && lm_s2_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    restart_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lm_s2_q) begin
          addr_d  = '0;
          idx_d   = '0;
          shreg_d = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        // Leaving wins over a simultaneous final nibble.
        if (!lm_s2_q) begin
          idx_d     = '0;
          restart_d = 1'b1;
          state_d   = IDLE;
        end else if (enter) begin
          shreg_d[DATA_W-1-NIB_W*int'(idx_q) -: NIB_W] = Nibble_Sw;
          if (idx_q == IDX_W'(NIBS - 1)) begin
            idx_d     = '0;
            wr_addr_d = addr_q;
            wr_data_d = shreg_d;
            state_d   = WRITE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      WRITE: begin
        if (&addr_q) begin
          state_d = FULL;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = COLLECT;
        end
      end
      FULL: begin
        if (!lm_s2_q) begin
          restart_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_100MHz or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      restart_q <= 1'b0;
      lm_s1_q   <= 1'b0;
      lm_s2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      restart_q <= restart_d;
      lm_s1_q   <= Load_Mode;
      lm_s2_q   <= lm_s1_q;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge Clk_100MHz or posedge Reset) begin
    if (Reset) begin
      csum_q <= '0;
    end else if (start) begin
      csum_q <= '0;
    end else if (state_q == WRITE) begin
      csum_q <= csum_q ^ wr_data_q;
    end
  end

  assign Checksum = csum_q;
`else
  logic unused_start;
  assign unused_start = start;
  assign Checksum     = '0;
`endif

  assign IMem_WrEn   = (state_q == WRITE);
  assign IMem_WrAddr = wr_addr_q;
  assign IMem_WrData = wr_data_q;
  assign Cpu_Hold    = (state_q != IDLE);
  assign Cpu_Restart = restart_q;
  assign Nib_Idx     = 2'(idx_q);
  assign Load_Full   = (state_q == FULL);

endmodule

// File: tb/tb_imem_switch_loader.sv
// Randomised scoreboard bench for imem_switch_loader (DEBOUNCE_CYCLES=4, ADDR_W=2).
// Expected writes come from a word/address model fed by each nibble press.
module tb_imem_switch_loader;

  logic        clk = 1'b0;
  logic        Reset;
  logic [3:0]  Nibble_Sw;
  logic        Enter_Btn;
  logic        Load_Mode;
  logic        IMem_WrEn;
  logic [1:0]  IMem_WrAddr;
  logic [15:0] IMem_WrData;
  logic        Cpu_Hold;
  logic        Cpu_Restart;
  logic [1:0]  Nib_Idx;
  logic        Load_Full;
  logic [15:0] Checksum;

  always #5 clk = ~clk;

  imem_switch_loader #(
    .DEBOUNCE_CYCLES(4),
    .ADDR_W         (2),
    .DATA_W         (16)
  ) dut (
    .Clk_100MHz (clk),
    .Reset      (Reset),
    .Nibble_Sw  (Nibble_Sw),
    .Enter_Btn  (Enter_Btn),
    .Load_Mode  (Load_Mode),
    .IMem_WrEn  (IMem_WrEn),
    .IMem_WrAddr(IMem_WrAddr),
    .IMem_WrData(IMem_WrData),
    .Cpu_Hold   (Cpu_Hold),
    .Cpu_Restart(Cpu_Restart),
    .Nib_Idx    (Nib_Idx),
    .Load_Full  (Load_Full),
    .Checksum   (Checksum)
  );

  typedef struct packed {
    logic [1:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   restarts_seen = 0;

  // Reference model: a session is a list of nibbles; every four make a word.
  bit          m_active;
  bit          m_full;
  logic [1:0]  m_addr;
  logic [15:0] m_csum;
  int          m_nibs[$];
  int          m_restarts = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void m_start();
    m_active = 1'b1;
    m_full   = 1'b0;
    m_addr   = '0;
    m_csum   = '0;
    m_nibs.delete();
  endfunction

  function automatic void m_nib(input logic [3:0] n);
    logic [15:0] w;
    if (!m_active || m_full) return;
    m_nibs.push_back(int'(n));
    if (m_nibs.size() == 4) begin
      w = 16'(m_nibs[0] * 4096 + m_nibs[1] * 256 + m_nibs[2] * 16 + m_nibs[3]);
      exp_q.push_back('{a: m_addr, d: w});
      m_csum = m_csum ^ w;
      if (m_addr == 2'd3) m_full = 1'b1;
      else m_addr = m_addr + 2'd1;
      m_nibs.delete();
    end
  endfunction

  function automatic void m_stop();
    m_active = 1'b0;
    m_restarts++;
    m_nibs.delete();
  endfunction

  always @(negedge clk) begin
    if (!Reset) begin
      if (IMem_WrEn) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                   IMem_WrAddr, IMem_WrData);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(IMem_WrAddr), 32'(e.a));
          chk("wr_data", 32'(IMem_WrData), 32'(e.d));
        end
      end
      if (Cpu_Restart) restarts_seen++;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_wren"},    32'(IMem_WrEn),   0);
    chk({tag, "_wraddr"},  32'(IMem_WrAddr), 0);
    chk({tag, "_wrdata"},  32'(IMem_WrData), 0);
    chk({tag, "_hold"},    32'(Cpu_Hold),    0);
    chk({tag, "_restart"}, 32'(Cpu_Restart), 0);
    chk({tag, "_idx"},     32'(Nib_Idx),     0);
    chk({tag, "_full"},    32'(Load_Full),   0);
    chk({tag, "_csum"},    32'(Checksum),    0);
  endtask

  task automatic chk_csum(input string name);
`ifdef LOADER_CHECKSUM_EN
    chk(name, 32'(Checksum), 32'(m_csum));
`else
    chk(name, 32'(Checksum), 0);
`endif
  endtask

  task automatic start_session();
    Load_Mode = 1'b1;
    m_start();
    for (int i = 0; i < 10 && !Cpu_Hold; i++) ticks(1);
    chk("hold_rise", 32'(Cpu_Hold), 1);
    chk("idx_start", 32'(Nib_Idx), 0);
  endtask

  task automatic end_session();
    Load_Mode = 1'b0;
    m_stop();
    for (int i = 0; i < 10 && Cpu_Hold; i++) ticks(1);
    chk("hold_fall", 32'(Cpu_Hold), 0);
    ticks(3);
    chk("restarts", 32'(restarts_seen), 32'(m_restarts));
    chk("full_clear", 32'(Load_Full), 0);
  endtask

  task automatic press(input logic [3:0] n);
    Nibble_Sw = n;
    m_nib(n);
    Enter_Btn = 1'b1;
    ticks(10);
    Enter_Btn = 1'b0;
    ticks(10);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] nb;
    int         nw;
    Reset     = 1'b1;
    Nibble_Sw = '0;
    Enter_Btn = 1'b0;
    Load_Mode = 1'b0;
    m_active  = 1'b0;
    m_full    = 1'b0;
    m_addr    = '0;
    m_csum    = '0;
    ticks(3);
    chk_zero("rst");
    Reset = 1'b0;
    ticks(3);

    // Words 0x1234 and 0xABCD.
    start_session();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    press(4'hA); press(4'hB); press(4'hC); press(4'hD);
`ifdef LOADER_CHECKSUM_EN
    chk("csum_b9f9", 32'(Checksum), 32'h0000_B9F9);
`else
    chk("csum_off", 32'(Checksum), 0);
`endif
    end_session();

    // Reset mid-word, two nibbles in.
    start_session();
    press(4'h7); press(4'h8);
    chk("idx_two", 32'(Nib_Idx), 2);
    @(posedge clk);
    #3 Reset = 1'b1;
    #1;
    chk_zero("midrst");
    m_active = 1'b0;
    m_nibs.delete();
    Load_Mode = 1'b0;
    ticks(2);
    Reset = 1'b0;
    ticks(6);
    chk("midrst_hold", 32'(Cpu_Hold), 0);
    chk("midrst_norestart", 32'(restarts_seen), 32'(m_restarts));

    // Bouncing button then a stable press.
    start_session();
    Nibble_Sw = 4'h5;
    m_nib(4'h5);
    for (int i = 0; i < 2; i++) begin
      Enter_Btn = 1'b1; ticks(2);
      Enter_Btn = 1'b0; ticks(2);
    end
    Enter_Btn = 1'b1;
    ticks(6);
    chk("bounce_early", 32'(Nib_Idx), 0);
    ticks(1);
    chk("bounce_capture", 32'(Nib_Idx), 1);
    ticks(20);
    chk("bounce_single", 32'(Nib_Idx), 1);
    Enter_Btn = 1'b0;
    ticks(12);
    end_session();

    // Fill all four addresses, then keep pressing.
    start_session();
    for (int i = 0; i < 16; i++) press(4'($urandom));
    chk("full_set", 32'(Load_Full), 1);
    press(4'($urandom));
    press(4'($urandom));
    chk("full_stay", 32'(Load_Full), 1);
    chk("full_hold", 32'(Cpu_Hold), 1);
    chk_csum("csum_full");
    end_session();

    // Abort after three nibbles, next session restarts at address 0.
    start_session();
    press(4'h3); press(4'h6); press(4'h9);
    end_session();
    start_session();
    press(4'hF); press(4'hE); press(4'h0); press(4'h1);
    chk("abort_idx", 32'(Nib_Idx), 0);
    chk_csum("csum_abort");
    end_session();

    // Load_Mode falls in the cycle of the fourth Enter pulse.
    start_session();
    press(4'h2); press(4'h4); press(4'h6);
    Nibble_Sw = 4'h8;
    Enter_Btn = 1'b1;
    ticks(4);
    Load_Mode = 1'b0;
    ticks(2);
    chk("race_hold_pre", 32'(Cpu_Hold), 1);
    ticks(1);
    chk("race_hold_post", 32'(Cpu_Hold), 0);
    chk("race_restart", 32'(Cpu_Restart), 1);
    m_stop();
    Enter_Btn = 1'b0;
    ticks(12);
    chk("race_restarts", 32'(restarts_seen), 32'(m_restarts));

    // Random sessions with optional trailing partial word.
    for (int s = 0; s < 3; s++) begin
      start_session();
      nw = int'($urandom_range(1, 3));
      for (int i = 0; i < 4 * nw; i++) press(4'($urandom));
      nb = 4'($urandom_range(0, 3));
      for (int i = 0; i < int'(nb); i++) press(4'($urandom));
      chk("rand_idx", 32'(Nib_Idx), 32'(nb));
      chk_csum("rand_csum");
      end_session();
    end

    ticks(5);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
